// File: rtl/spu_bitcount_pkg.sv
// Shared types and constants for the SPU frame bit-count accumulator.
package spu_bitcount_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam logic MODE_ZEROS = 1'b0;
    localparam logic MODE_ONES  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/word_bit_counter.sv
// Combinational zero/one population count of a single data word.
module word_bit_counter
    import spu_bitcount_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int CNT_W = clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CNT_W'(data[i]);
        end
        if (mode == MODE_ZEROS) begin
            count = CNT_W'(WIDTH) - ones;
        end else begin
            count = ones;
        end
    end

endmodule

// File: rtl/bit_count_accum.sv
// Streaming frame bit counter: per-word count stage feeding a frame accumulator,
// total offered on a valid/ready result port.
module bit_count_accum
    import spu_bitcount_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  MAX_WORDS = 256,
    localparam int CNT_W     = clog2(WIDTH) + 1,
    localparam int LEN_W     = clog2(MAX_WORDS) + 1,
    localparam int ACC_W     = CNT_W + LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             busy
);

    state_e           state;
    state_e           next_state;
    logic             mode_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] stage;
    logic             stage_v;
    logic [ACC_W-1:0] acc;
    logic             accept;
    logic             start_ok;

    word_bit_counter #(.WIDTH(WIDTH)) u_counter (
        .data  (in_data),
        .mode  (mode_q),
        .count (word_count)
    );

    assign len_clamped = (frame_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : frame_len;
    assign accept      = in_valid & in_ready;
    assign start_ok    = (state == IDLE) & start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_count  = '0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = (remaining != '0);
                if (in_valid && in_ready && remaining == LEN_W'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_count = acc;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Count is registered on accept and folded into acc one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_ZEROS;
            remaining <= '0;
            stage     <= '0;
            stage_v   <= 1'b0;
            acc       <= '0;
        end else begin
            stage_v <= accept;
            if (accept) begin
                stage     <= word_count;
                remaining <= remaining - LEN_W'(1);
            end
            if (start_ok) begin
                mode_q    <= mode;
                remaining <= len_clamped;
                acc       <= '0;
            end else if (stage_v) begin
                acc <= acc + ACC_W'(stage);
            end
        end
    end

endmodule

// File: tb/tb_bit_count_accum.sv
// Directed self-checking bench for bit_count_accum (WIDTH=16, MAX_WORDS=256).
`timescale 1ns/1ps
module tb_bit_count_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [8:0]  frame_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bit_count_accum #(.WIDTH(16), .MAX_WORDS(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic m, input logic [8:0] len);
        start     = 1'b1;
        mode      = m;
        frame_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds in_valid high; caller decides when to drop it.
    task automatic send(input logic [15:0] d, input string tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check({tag, "_out_timeout"}, 0, 1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_out_valid"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        frame_len = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zeros, back-to-back, exact latency
        start_frame(1'b0, 9'd3);
        check("t1_busy_after_start", busy, 1);
        send(16'h0000, "t1w0");
        send(16'hFFFF, "t1w1");
        send(16'h00FF, "t1w2");
        in_valid = 1'b0;
        check("t1_in_ready_after_last", in_ready, 0);
        check("t1_out_valid_e1", out_valid, 0);
        check("t1_busy_drain", busy, 1);
        @(negedge clk);
        check("t1_out_valid_e2", out_valid, 1);
        check("t1_out_count", out_count, 24);
        handshake("t1");

        // 2: ones, held result under back-pressure
        start_frame(1'b1, 9'd4);
        for (int i = 0; i < 4; i++) send(16'hFFFF, "t2w");
        in_valid = 1'b0;
        wait_out("t2");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_count", out_count, 64);
            @(negedge clk);
        end
        handshake("t2");

        // 3: empty frame
        start_frame(1'b0, 9'd0);
        check("t3_out_valid", out_valid, 1);
        check("t3_out_count", out_count, 0);
        check("t3_in_ready", in_ready, 0);
        handshake("t3");

        // 4: gaps and an extra word offered past the frame
        start_frame(1'b1, 9'd2);
        @(negedge clk);
        send(16'h0001, "t4w0");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        send(16'h8001, "t4w1");
        in_data = 16'hFFFF;
        check("t4_in_ready_after_last", in_ready, 0);
        @(negedge clk);
        check("t4_out_valid", out_valid, 1);
        check("t4_out_count", out_count, 3);
        in_valid = 1'b0;
        handshake("t4");

        // 5: reset aborts a frame
        start_frame(1'b0, 9'd4);
        send(16'h0000, "t5w0");
        send(16'h0000, "t5w1");
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_count", out_count, 0);
        check("t5_rst_busy", busy, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check("t5_no_stale_result", seen_valid, 0);
        start_frame(1'b0, 9'd1);
        send(16'h0F0F, "t5w2");
        in_valid = 1'b0;
        wait_out("t5");
        check("t5_out_count", out_count, 8);
        handshake("t5");

        // 6: full-length frame, start ignored during RUN and DONE
        start_frame(1'b0, 9'd256);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                start     = 1'b1;
                mode      = 1'b1;
                frame_len = 9'd1;
            end
            send(16'h0000, "t6w");
            start = 1'b0;
        end
        in_valid = 1'b0;
        wait_out("t6");
        check("t6_out_count", out_count, 4096);
        start     = 1'b1;
        frame_len = 9'd5;
        handshake("t6");
        start = 1'b0;

        // 7: frame_len above MAX_WORDS is clamped
        start_frame(1'b1, 9'd300);
        for (int i = 0; i < 256; i++) send(16'h0001, "t7w");
        check("t7_in_ready_after_clamp", in_ready, 0);
        in_valid = 1'b0;
        wait_out("t7");
        check("t7_out_count", out_count, 256);
        handshake("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
